conv_frame_encoder: RTL and testbench

//  Rate-1/2 convolutional encoder with frame termination. It is the transmit end of the Viterbi link: it feeds the

---
 rtl/conv_frame_encoder_if.sv | 24 ++
 rtl/conv_frame_encoder.sv | 131 +++++++++++++
 tb/tb_conv_frame_encoder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_encoder_if.sv
// Handshake bundle for the convolutional frame encoder: bit input side
// (enable/ready) and symbol output side (valid/ready) with frame markers.
interface conv_frame_encoder_if;
  logic       enable_i;
  logic       d_in;
  logic       last_i;
  logic       ready_o;
  logic       valid_o;
  logic [1:0] d_out;
  logic       last_o;
  logic       ready_i;

  // Producer of data bits and consumer of symbols.
  modport master (
    output enable_i, d_in, last_i, ready_i,
    input  ready_o, valid_o, d_out, last_o
  );

  // The encoder itself.
  modport slave (
    input  enable_i, d_in, last_i, ready_i,
    output ready_o, valid_o, d_out, last_o
  );
endinterface

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination.
// Input bits arrive over enable/ready, 2-bit symbols leave through a
// one-deep output register with downstream backpressure.
module conv_frame_encoder #(
  parameter int           K       = 3,
  parameter logic [K-1:0] G0      = 3'b111,
  parameter logic [K-1:0] G1      = 3'b101,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_frame_encoder_if.slave  bus,
  output logic                 busy_o,
  output logic [15:0]          frame_ct_o
);

  localparam int           TW        = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [K-2:0]  sr, sr_n;          // sr[K-2] is the most recent bit
  logic [TW-1:0] tail_ct, tail_ct_n;

  logic          slot_free;
  logic          accept;
  logic          tail_emit;
  logic          tail_done;
  logic          load;
  logic          b;
  logic [K-1:0]  r;
  logic [1:0]    sym;
  logic          sym_last;

  // The output register can take a new symbol when it is empty or being drained.
  assign slot_free   = !bus.valid_o || bus.ready_i;
  assign bus.ready_o = (state != TAIL) && slot_free;
  assign accept      = bus.enable_i && bus.ready_o;
  assign tail_emit   = (state == TAIL) && slot_free;
  assign tail_done   = tail_emit && (tail_ct == TAIL_LAST);
  assign load        = accept || tail_emit;

  // Tail symbols encode a zero bit; data symbols encode the accepted bit.
  assign b        = accept && bus.d_in;
  assign r        = {b, sr};
  assign sym      = {^(r & G0), ^(r & G1)};
  assign sym_last = tail_done || (accept && bus.last_i && !TAIL_EN);

  assign busy_o = (state != IDLE) || bus.valid_o;

  // State, shift register and tail counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      tail_ct <= '0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      tail_ct <= tail_ct_n;
    end
  end

  // Next-state logic: frame progression and shift-register update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n   = state;
    sr_n      = sr;
    tail_ct_n = tail_ct;
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          sr_n    = r[K-1:1];
          state_n = DATA;
          if (bus.last_i) begin
            if (TAIL_EN) begin
              state_n   = TAIL;
              tail_ct_n = '0;
            end else begin
              state_n = IDLE;
              sr_n    = '0;
            end
          end
        end
      end
      TAIL: begin
        if (tail_emit) begin
          sr_n = r[K-1:1];
          if (tail_done) begin
            state_n   = IDLE;
            tail_ct_n = '0;
          end else begin
            tail_ct_n = tail_ct + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One-deep output register and completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_o <= 1'b0;
      bus.d_out   <= 2'b00;
      bus.last_o  <= 1'b0;
      frame_ct_o  <= 16'd0;
    end else begin
      if (load) begin
        bus.valid_o <= 1'b1;
        bus.d_out   <= sym;
        bus.last_o  <= sym_last;
      end else if (bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
      // Counted when the closing symbol is loaded, not when it leaves.
      if (load && sym_last) begin
        frame_ct_o <= frame_ct_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench for conv_frame_encoder: a tail-terminated instance (a)
// and a no-tail instance (b), checked against a convolution-sum model.
module tb_conv_frame_encoder;

  localparam int           K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [2:0] sym_t;   // {last, d_out[1], d_out[0]}
  typedef bit   bits_t[$];
  typedef sym_t syms_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_frame_encoder_if bus_a ();
  conv_frame_encoder_if bus_b ();
  logic        busy_a, busy_b;
  logic [15:0] fct_a, fct_b;

  conv_frame_encoder #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy_o(busy_a), .frame_ct_o(fct_a)
  );
  conv_frame_encoder #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy_o(busy_b), .frame_ct_o(fct_b)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    rmode    = 0;
  int    pat      = 0;
  logic  rdy      = 1'b1;
  syms_t exp_a, exp_b;
  int    frames_a = 0, frames_b = 0;
  bit    stall_a = 1'b0, stall_b = 1'b0;
  sym_t  held_a, held_b;
  bit    acc_a, acc_b;
  logic  samp_ready_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each output is the GF(2) convolution of the frame's bit
  // sequence (zero before the frame, zero-padded by K-1 when tailed).
  function automatic syms_t encode(input bits_t bits, input bit tail_en);
    syms_t out;
    int n     = bits.size();
    int total = tail_en ? n + K - 1 : n;
    for (int i = 0; i < total; i++) begin
      bit p1 = 1'b0;
      bit p0 = 1'b0;
      for (int j = 0; j < K; j++) begin
        bit x = (i - j >= 0 && i - j < n) ? bits[i-j] : 1'b0;
        p1 ^= G0[K-1-j] & x;
        p0 ^= G1[K-1-j] & x;
      end
      out.push_back({(i == total - 1), p1, p0});
    end
    return out;
  endfunction

  task automatic set_mode(input int m);
    rmode = m;
    pat   = 0;
    rdy   = 1'b1;
    bus_a.ready_i = rdy;
    bus_b.ready_i = rdy;
  endtask

  task automatic idle();
    bus_a.enable_i = 1'b0;
    bus_b.enable_i = 1'b0;
  endtask

  // One clock: observe on the falling edge, then drive after the rising edge.
  task automatic tick();
    @(negedge clk);
    acc_a        = (bus_a.enable_i & bus_a.ready_o) === 1'b1;
    acc_b        = (bus_b.enable_i & bus_b.ready_o) === 1'b1;
    samp_ready_a = bus_a.ready_o;
    if (stall_a) check("hold_a", {bus_a.valid_o, bus_a.last_o, bus_a.d_out}, {1'b1, held_a});
    if (stall_b) check("hold_b", {bus_b.valid_o, bus_b.last_o, bus_b.d_out}, {1'b1, held_b});
    if (bus_a.valid_o === 1'b1 && rdy === 1'b1) begin
      if (exp_a.size() > 0) check("sym_a", {1'b0, bus_a.last_o, bus_a.d_out}, {1'b0, exp_a.pop_front()});
      else                  check("extra_sym_a", {1'b0, bus_a.last_o, bus_a.d_out}, 4'b1000);
    end
    if (bus_b.valid_o === 1'b1 && rdy === 1'b1) begin
      if (exp_b.size() > 0) check("sym_b", {1'b0, bus_b.last_o, bus_b.d_out}, {1'b0, exp_b.pop_front()});
      else                  check("extra_sym_b", {1'b0, bus_b.last_o, bus_b.d_out}, 4'b1000);
    end
    stall_a = (bus_a.valid_o === 1'b1) && (rdy === 1'b0);
    stall_b = (bus_b.valid_o === 1'b1) && (rdy === 1'b0);
    held_a  = {bus_a.last_o, bus_a.d_out};
    held_b  = {bus_b.last_o, bus_b.d_out};
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      1:       rdy = (pat % 3 == 0);
      2:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = 1'b1;
    endcase
    pat++;
    bus_a.ready_i = rdy;
    bus_b.ready_i = rdy;
  endtask

  task automatic send_bit(input bit which, input bit d, input bit last);
    if (which) begin
      bus_b.enable_i = 1'b1; bus_b.d_in = d; bus_b.last_i = last;
    end else begin
      bus_a.enable_i = 1'b1; bus_a.d_in = d; bus_a.last_i = last;
    end
    for (int t = 0; t < 100; t++) begin
      tick();
      if (which ? acc_b : acc_a) return;
    end
    check("accept_timeout", which ? acc_b : acc_a, 1);
  endtask

  task automatic add_frame(input bit which, input bits_t bits);
    syms_t s = encode(bits, !which);
    foreach (s[i]) begin
      if (which) exp_b.push_back(s[i]);
      else       exp_a.push_back(s[i]);
    end
    if (which) frames_b++;
    else       frames_a++;
  endtask

  task automatic send_frame(input bit which, input bits_t bits, input bit gaps);
    add_frame(which, bits);
    foreach (bits[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
      send_bit(which, bits[i], i == bits.size() - 1);
    end
  endtask

  task automatic drain(input bit which);
    idle();
    for (int t = 0; t < 400; t++) begin
      if (which ? (exp_b.size() == 0 && bus_b.valid_o === 1'b0)
                : (exp_a.size() == 0 && bus_a.valid_o === 1'b0)) break;
      tick();
    end
    check(which ? "drain_b" : "drain_a", which ? exp_b.size() : exp_a.size(), 0);
    check(which ? "frame_ct_b" : "frame_ct_a", which ? fct_b : fct_a, which ? frames_b : frames_a);
    check(which ? "busy_idle_b" : "busy_idle_a", which ? busy_b : busy_a, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    set_mode(0);
    tick();
    tick();
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    frames_a = 0;
    frames_b = 0;
  endtask

  bits_t golden, fr;
  int    c0;

  initial begin
    rst = 1'b1;
    bus_a.enable_i = 1'b0; bus_a.d_in = 1'b0; bus_a.last_i = 1'b0; bus_a.ready_i = 1'b1;
    bus_b.enable_i = 1'b0; bus_b.d_in = 1'b0; bus_b.last_i = 1'b0; bus_b.ready_i = 1'b1;
    golden = '{1, 0, 1, 1};

    // Reset state.
    do_reset();
    check("rst_valid",   bus_a.valid_o, 0);
    check("rst_ready",   bus_a.ready_o, 1);
    check("rst_dout",    bus_a.d_out,   0);
    check("rst_last",    bus_a.last_o,  0);
    check("rst_fct",     fct_a,         0);
    check("rst_busy",    busy_a,        0);
    check("rst_valid_b", bus_b.valid_o, 0);
    check("rst_fct_b",   fct_b,         0);

    // Golden frame at full rate: 11,10,00,01,01,11; two tail cycles not ready.
    add_frame(0, golden);
    send_bit(0, 1, 0);
    check("latency", bus_a.valid_o, 1);
    check("busy_mid", busy_a, 1);
    send_bit(0, 0, 0);
    send_bit(0, 1, 0);
    send_bit(0, 1, 1);
    idle();
    tick(); check("tail_ready0", samp_ready_a, 0);
    tick(); check("tail_ready1", samp_ready_a, 0);
    tick(); check("post_tail_ready", samp_ready_a, 1);
    drain(0);

    // Backpressure with ready_i = 1,0,0,1,0,0,...
    set_mode(1);
    send_frame(0, golden, 0);
    drain(0);

    // Back-to-back frames with enable held: 12 symbols in 10 input-side cycles.
    set_mode(0);
    c0 = cyc;
    send_frame(0, golden, 0);
    send_frame(0, golden, 0);
    check("b2b_cycles", cyc - c0, 10);
    drain(0);

    // Reset mid-frame, then a fresh 2-bit frame from the zero state.
    exp_a.push_back(3'b011);
    exp_a.push_back(3'b010);
    send_bit(0, 1, 0);
    send_bit(0, 0, 0);
    do_reset();
    check("midrst_valid", bus_a.valid_o, 0);
    check("midrst_dout",  bus_a.d_out,   0);
    check("midrst_fct",   fct_a,         0);
    check("midrst_busy",  busy_a,        0);
    fr = '{1, 1};
    send_frame(0, fr, 0);
    drain(0);

    // No-tail instance: 1,0,1(last) then 1(last), back to back.
    fr = '{1, 0, 1};
    send_frame(1, fr, 0);
    fr = '{1};
    send_frame(1, fr, 0);
    drain(1);

    // Randomized frames, gaps and backpressure on both instances.
    set_mode(2);
    for (int f = 0; f < 15; f++) begin
      fr.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) fr.push_back(1'($urandom_range(0, 1)));
      send_frame(0, fr, 1);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        tick();
      end
    end
    drain(0);
    for (int f = 0; f < 10; f++) begin
      fr.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) fr.push_back(1'($urandom_range(0, 1)));
      send_frame(1, fr, 1);
    end
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
